// File: rtl/sfr_timer_multi.sv
// sfr_timer_multi: free-running SFR timer with NCH independent compare channels.
//
// A CW-bit counter advances on every clock where CTRL.en and drun are both high. Each
// channel compares the counter against its own compare value. A channel can be off,
// one-shot (disarms itself after the first match) or periodic (the compare value
// advances by a 16-bit period after each match). A match latches a per-channel pending
// bit. irqrun is the OR of the pending bits that are also set in MASK.
//
// Ports:
//   clk      in   single clock, all state changes on the rising edge
//   nreset   in   synchronous active-low reset
//   drun     in   core running; the counter is frozen while low
//   sel      in   SFR block select
//   r        in   read strobe
//   addr     in   byte address, bit 0 ignored
//   w        in   byte-lane write strobes (w[1] = dwrite[15:8], w[0] = dwrite[7:0])
//   dwrite   in   write data
//   sfr_data out  combinational read data, zero unless r & sel hit a mapped register
//   irqrun   out  interrupt request
module sfr_timer_multi #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 32,
    parameter logic [7:0]  BASE = 8'h00
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        drun,
    input  logic        sel,
    input  logic        r,
    input  logic [7:0]  addr,
    input  logic [1:0]  w,
    input  logic [15:0] dwrite,
    output logic [15:0] sfr_data,
    output logic        irqrun
);

    // Width of the upper half of the counter and compare registers.
    localparam int unsigned HW = CW - 16;

    logic [CW-1:0]  count_q, count_d;
    logic           en_q, en_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [CW-1:0]  cmp_q    [NCH];
    logic [CW-1:0]  cmp_d    [NCH];
    logic [15:0]    period_q [NCH];
    logic [15:0]    period_d [NCH];
    logic [1:0]     mode_q   [NCH];
    logic [1:0]     mode_d   [NCH];

    logic           tick;
    logic [CW-1:0]  count_inc;
    logic [NCH-1:0] match;
    logic [NCH-1:0] ch_hit;
    logic [6:0]     word;
    logic [1:0]     wl;

    // Replace only the byte lanes selected by lanes.
    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] data,
                                            input logic [1:0] lanes);
        merge16 = {lanes[1] ? data[15:8] : old[15:8], lanes[0] ? data[7:0] : old[7:0]};
    endfunction

    // Word index relative to BASE; the subtraction wraps so addresses below BASE land
    // in the unmapped top of the window.
    assign word = 7'((addr - BASE) >> 1);
    assign wl   = sel ? w : 2'b00;
    assign tick = en_q & drun;

    // Channel i occupies words 8+4i .. 11+4i.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_hit[i] = (word[6:2] == 5'(i + 2));
        end
    end

    // Matches use the pre-increment count.
    always_comb begin
        match = '0;
        for (int i = 0; i < NCH; i++) begin
            match[i] = tick & (mode_q[i] != 2'd0) & (count_q == cmp_q[i]);
        end
    end

    assign count_inc = tick ? count_q + CW'(1) : count_q;

    always_comb begin
        // Software writes win over the increment for the written lanes only.
        count_d = count_inc;
        if (word == 7'd3) begin
            count_d[CW-1:16] = HW'(merge16(16'(count_inc >> 16), dwrite, wl));
        end
        if (word == 7'd4) begin
            count_d[15:0] = merge16(count_inc[15:0], dwrite, wl);
        end

        en_d = en_q;
        if (word == 7'd0 && wl[0]) begin
            en_d = dwrite[0];
        end

        // W1C is applied before the hardware set so a same-cycle match wins.
        pending_d = pending_q;
        if (word == 7'd1 && wl[0]) begin
            pending_d = pending_d & ~dwrite[NCH-1:0];
        end
        pending_d = pending_d | match;

        mask_d = mask_q;
        if (word == 7'd2 && wl[0]) begin
            mask_d = dwrite[NCH-1:0];
        end

        for (int i = 0; i < NCH; i++) begin
            // Mode bit 1 set means periodic (modes 2 and 3).
            cmp_d[i]    = (match[i] && mode_q[i][1]) ? cmp_q[i] + CW'(period_q[i]) : cmp_q[i];
            period_d[i] = period_q[i];
            mode_d[i]   = (match[i] && mode_q[i] == 2'd1) ? 2'd0 : mode_q[i];
            if (ch_hit[i]) begin
                case (word[1:0])
                    2'd0: cmp_d[i][CW-1:16] = HW'(merge16(16'(cmp_d[i] >> 16), dwrite, wl));
                    2'd1: cmp_d[i][15:0] = merge16(cmp_d[i][15:0], dwrite, wl);
                    2'd2: period_d[i] = merge16(period_q[i], dwrite, wl);
                    default: begin
                        if (wl[0]) begin
                            mode_d[i] = dwrite[1:0];
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            count_q   <= '0;
            en_q      <= 1'b0;
            pending_q <= '0;
            mask_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                cmp_q[i]    <= '1;
                period_q[i] <= '0;
                mode_q[i]   <= '0;
            end
        end else begin
            count_q   <= count_d;
            en_q      <= en_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            for (int i = 0; i < NCH; i++) begin
                cmp_q[i]    <= cmp_d[i];
                period_q[i] <= period_d[i];
                mode_q[i]   <= mode_d[i];
            end
        end
    end

    always_comb begin
        sfr_data = 16'h0000;
        if (r && sel) begin
            case (word)
                7'd0:    sfr_data = {15'b0, en_q};
                7'd1:    sfr_data = 16'(pending_q);
                7'd2:    sfr_data = 16'(mask_q);
                7'd3:    sfr_data = 16'(count_q >> 16);
                7'd4:    sfr_data = count_q[15:0];
                default: sfr_data = 16'h0000;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (ch_hit[i]) begin
                    case (word[1:0])
                        2'd0:    sfr_data = 16'(cmp_q[i] >> 16);
                        2'd1:    sfr_data = cmp_q[i][15:0];
                        2'd2:    sfr_data = period_q[i];
                        default: sfr_data = {14'b0, mode_q[i]};
                    endcase
                end
            end
        end
    end

    assign irqrun = |(pending_q & mask_q);

endmodule

// File: tb/tb_sfr_timer_multi.sv
module tb_sfr_timer_multi;
    localparam int          NCH   = 4;
    localparam int          CW    = 20;
    localparam logic [7:0]  BASE  = 8'h40;
    localparam int unsigned CMASK = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        drun = 1'b0;
    logic        sel = 1'b0;
    logic        r = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [1:0]  w = 2'b00;
    logic [15:0] dwrite = 16'h0000;
    logic [15:0] sfr_data;
    logic        irqrun;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int unsigned m_count, m_pend, m_mask;
    bit          m_en;
    int unsigned m_cmp [NCH];
    int unsigned m_per [NCH];
    int unsigned m_mode[NCH];

    sfr_timer_multi #(.NCH(NCH), .CW(CW), .BASE(BASE)) dut (
        .clk(clk), .nreset(nreset), .drun(drun), .sel(sel), .r(r), .addr(addr),
        .w(w), .dwrite(dwrite), .sfr_data(sfr_data), .irqrun(irqrun)
    );

    always #50 clk = ~clk;

    function automatic logic [7:0] ra(input int off);
        return 8'(int'(BASE) + off);
    endfunction

    function automatic logic [7:0] ca(input int ch, input int sub);
        return 8'(int'(BASE) + 16 + 8 * ch + sub);
    endfunction

    function automatic int unsigned lanes_merge(input int unsigned old, input logic [15:0] d,
                                                input logic [1:0] wl);
        int unsigned m;
        m = (wl[1] ? 32'hFF00 : 32'h0) | (wl[0] ? 32'h00FF : 32'h0);
        return (old & ~m) | (32'(d) & m);
    endfunction

    function automatic logic [15:0] mread(input logic [7:0] a);
        int off, ch, sub;
        int unsigned v;
        off = int'(8'(a - BASE)) & 'hFE;
        v = 0;
        if (off == 0) v = m_en;
        else if (off == 2) v = m_pend;
        else if (off == 4) v = m_mask;
        else if (off == 6) v = m_count >> 16;
        else if (off == 8) v = m_count & 'hFFFF;
        else if (off >= 16) begin
            ch = (off - 16) / 8;
            sub = (off - 16) % 8;
            if (ch < NCH) begin
                if (sub == 0) v = m_cmp[ch] >> 16;
                else if (sub == 2) v = m_cmp[ch] & 'hFFFF;
                else if (sub == 4) v = m_per[ch];
                else v = m_mode[ch];
            end
        end
        return 16'(v);
    endfunction

    function automatic bit mirq();
        return (m_pend & m_mask) != 0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_pend = 0; m_mask = 0; m_en = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cmp[i] = CMASK; m_per[i] = 0; m_mode[i] = 0;
        end
    endtask

    // One clock edge with an optional bus write; the model advances alongside.
    task automatic step(input bit wv, input logic [7:0] wa, input logic [15:0] wd,
                        input logic [1:0] wl);
        int unsigned nc, npend, clr, nmask, hit;
        int unsigned ncmp [NCH];
        int unsigned nper [NCH];
        int unsigned nmode[NCH];
        bit nen, tk;
        int off, ch, sub;
        sel = wv; addr = wa; dwrite = wd; w = wv ? wl : 2'b00; r = 1'b0;
        tk = m_en && drun;
        hit = 0;
        for (int i = 0; i < NCH; i++) begin
            ncmp[i] = m_cmp[i]; nper[i] = m_per[i]; nmode[i] = m_mode[i];
            if (tk && m_mode[i] != 0 && m_count == m_cmp[i]) begin
                hit |= (1 << i);
                if (m_mode[i] == 1) nmode[i] = 0;
                else ncmp[i] = (m_cmp[i] + m_per[i]) & CMASK;
            end
        end
        nc = tk ? (m_count + 1) & CMASK : m_count;
        clr = 0; nen = m_en; nmask = m_mask;
        if (wv) begin
            off = int'(8'(wa - BASE)) & 'hFE;
            if (off == 0 && wl[0]) nen = wd[0];
            else if (off == 2 && wl[0]) clr = wd & 'hF;
            else if (off == 4 && wl[0]) nmask = wd & 'hF;
            else if (off == 6) nc = ((lanes_merge(nc >> 16, wd, wl) << 16) | (nc & 'hFFFF)) & CMASK;
            else if (off == 8) nc = (nc & ~32'hFFFF) | lanes_merge(nc & 'hFFFF, wd, wl);
            else if (off >= 16) begin
                ch = (off - 16) / 8;
                sub = (off - 16) % 8;
                if (ch < NCH) begin
                    if (sub == 0)
                        ncmp[ch] = ((lanes_merge(ncmp[ch] >> 16, wd, wl) << 16)
                                    | (ncmp[ch] & 'hFFFF)) & CMASK;
                    else if (sub == 2)
                        ncmp[ch] = (ncmp[ch] & ~32'hFFFF) | lanes_merge(ncmp[ch] & 'hFFFF, wd, wl);
                    else if (sub == 4) nper[ch] = lanes_merge(nper[ch], wd, wl);
                    else if (wl[0]) nmode[ch] = wd & 3;
                end
            end
        end
        npend = (m_pend & ~clr) | hit;
        @(posedge clk);
        #1;
        m_count = nc; m_pend = npend; m_mask = nmask; m_en = nen;
        for (int i = 0; i < NCH; i++) begin
            m_cmp[i] = ncmp[i]; m_per[i] = nper[i]; m_mode[i] = nmode[i];
        end
        sel = 1'b0; w = 2'b00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        step(1'b1, a, d, 2'b11);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 16'h0000, 2'b00);
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        sel = 1'b1; r = 1'b1; addr = a;
        #1;
        d = sfr_data;
        sel = 1'b0; r = 1'b0;
    endtask

    // Advance until the model count reaches target, with a cycle budget.
    task automatic run_to(input int unsigned target);
        int n;
        n = 0;
        while (m_count != target && n < 400) begin
            idle();
            n++;
        end
        checks++;
        if (m_count != target) begin
            errors++;
            $display("FAIL run_to: count %h target %h not reached", m_count, target);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        nreset = 1'b0; drun = 1'b1; sel = 1'b1; w = 2'b11; dwrite = 16'hFFFF; addr = ra(0);
        @(posedge clk); #1;
        addr = ra(8);
        @(posedge clk); #1;
        nreset = 1'b1; sel = 1'b0; w = 2'b00;
        model_reset();
        for (int k = 0; k < 5 + 4 * NCH; k++) begin
            logic [7:0] a;
            a = (k < 5) ? ra(2 * k) : ca((k - 5) / 4, ((k - 5) % 4) * 2);
            rd(a, d);
            checks++;
            if (d !== mread(a)) begin
                errors++;
                $display("FAIL reset_reg %h: got %h expected %h", a, d, mread(a));
            end
        end
        rd(ca(0, 0), d);
        checks++;
        if (d !== 16'h000F) begin
            errors++; $display("FAIL reset_cmp_hi: got %h expected 000f", d);
        end
        checks++;
        if (irqrun !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", irqrun);
        end
        sel = 1'b0; r = 1'b1; addr = ca(0, 2);
        #1;
        checks++;
        if (sfr_data !== 16'h0000) begin
            errors++; $display("FAIL reset_nosel: got %h expected 0000", sfr_data);
        end
        r = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        drun = 1'b1;
        wr(ca(0, 0), 16'h0000); wr(ca(0, 2), 16'h0010); wr(ca(0, 6), 16'h0001);
        wr(ra(4), 16'h0001); wr(ra(0), 16'h0001);
        for (int k = 1; k <= 17; k++) begin
            idle();
            checks++;
            if (irqrun !== (k == 17)) begin
                errors++; $display("FAIL oneshot_irq step %0d: got %b expected %b", k, irqrun, k == 17);
            end
        end
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL oneshot_pend: got %h expected 0001", d); end
        rd(ca(0, 6), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_mode: got %h expected 0000", d); end
        rd(ra(8), d);
        checks++;
        if (d !== 16'h0011) begin errors++; $display("FAIL oneshot_count: got %h expected 0011", d); end
        step(1'b1, ra(2), 16'h0001, 2'b01);
        checks++;
        if (irqrun !== 1'b0) begin errors++; $display("FAIL oneshot_w1c: got %b expected 0", irqrun); end
        wr(ra(0), 16'h0000); wr(ra(6), 16'h000F); wr(ra(8), 16'hFFF0); wr(ra(0), 16'h0001);
        for (int k = 0; k < 40; k++) begin
            idle();
            checks++;
            if (irqrun !== 1'b0) begin errors++; $display("FAIL oneshot_rearm: got %b expected 0", irqrun); end
        end
        rd(ra(8), d);
        checks++;
        if (d !== 16'h0018) begin errors++; $display("FAIL oneshot_wrapcount: got %h expected 0018", d); end
    endtask

    task automatic test_periodic();
        logic [15:0] d;
        wr(ra(0), 16'h0000); wr(ra(6), 16'h0000); wr(ra(8), 16'h0000);
        wr(ca(1, 0), 16'h0000); wr(ca(1, 2), 16'h0020); wr(ca(1, 4), 16'h0010);
        wr(ca(1, 6), 16'h0002); wr(ra(4), 16'h0002); wr(ra(0), 16'h0001);
        run_to(32'h21);
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0002 || irqrun !== 1'b1) begin
            errors++; $display("FAIL periodic_first: pend %h irq %b expected 0002 1", d, irqrun);
        end
        step(1'b1, ra(2), 16'h0002, 2'b01);
        run_to(32'h30);
        drun = 1'b0;
        for (int k = 0; k < 5; k++) idle();
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL periodic_stall_pend: got %h expected 0000", d); end
        rd(ra(8), d);
        checks++;
        if (d !== 16'h0030) begin errors++; $display("FAIL periodic_stall_cnt: got %h expected 0030", d); end
        drun = 1'b1;
        idle();
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0002) begin errors++; $display("FAIL periodic_second: got %h expected 0002", d); end
        rd(ca(1, 2), d);
        checks++;
        if (d !== 16'h0040) begin errors++; $display("FAIL periodic_reload1: got %h expected 0040", d); end
        step(1'b1, ra(2), 16'h0002, 2'b01);
        run_to(32'h41);
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0002) begin errors++; $display("FAIL periodic_third: got %h expected 0002", d); end
        rd(ca(1, 2), d);
        checks++;
        if (d !== 16'h0050) begin errors++; $display("FAIL periodic_reload2: got %h expected 0050", d); end
        wr(ca(1, 6), 16'h0000);
        step(1'b1, ra(2), 16'h000F, 2'b01);
    endtask

    task automatic test_races();
        logic [15:0] d;
        wr(ra(0), 16'h0000); wr(ra(6), 16'h0000); wr(ra(8), 16'h0100);
        wr(ca(2, 0), 16'h0000); wr(ca(2, 2), 16'h0105); wr(ca(2, 6), 16'h0001);
        wr(ra(4), 16'h0004); wr(ra(0), 16'h0001);
        run_to(32'h105);
        step(1'b1, ra(2), 16'h0004, 2'b01);
        rd(ra(2), d);
        checks++;
        if (d[2] !== 1'b1) begin errors++; $display("FAIL race_w1c_set: got %h expected bit2 set", d); end
        step(1'b1, ra(2), 16'h0004, 2'b01);
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL race_w1c_clear: got %h expected 0000", d); end
        wr(ra(0), 16'h0000); wr(ra(6), 16'h0001); wr(ra(8), 16'h11FF); wr(ra(0), 16'h0001);
        step(1'b1, ra(8), 16'h1234, 2'b01);
        rd(ra(8), d);
        checks++;
        if (d !== 16'h1234) begin errors++; $display("FAIL race_count_lo: got %h expected 1234", d); end
        rd(ra(6), d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL race_count_hi: got %h expected 0001", d); end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        wr(ra(0), 16'h0000); wr(ra(6), 16'h000F); wr(ra(8), 16'hFFFF);
        rd(ra(6), d);
        checks++;
        if (d !== 16'h000F) begin errors++; $display("FAIL wrap_hi_before: got %h expected 000f", d); end
        wr(ca(3, 0), 16'h0000); wr(ca(3, 2), 16'h0005); wr(ca(3, 4), 16'h0006);
        wr(ca(3, 6), 16'h0002); wr(ra(4), 16'h0008); step(1'b1, ra(2), 16'h000F, 2'b01);
        wr(ra(0), 16'h0001);
        idle();
        rd(ra(8), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL wrap_lo: got %h expected 0000", d); end
        rd(ra(6), d);
        checks++;
        if (d !== 16'h0000) begin errors++; $display("FAIL wrap_hi_after: got %h expected 0000", d); end
        run_to(32'h6);
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL wrap_fire5: got %h expected 0008", d); end
        step(1'b1, ra(2), 16'h0008, 2'b01);
        run_to(32'hC);
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0008) begin errors++; $display("FAIL wrap_fireB: got %h expected 0008", d); end
        rd(ca(3, 2), d);
        checks++;
        if (d !== 16'h0011) begin errors++; $display("FAIL wrap_reload: got %h expected 0011", d); end
        wr(ca(3, 6), 16'h0000);
        step(1'b1, ra(2), 16'h000F, 2'b01);
    endtask

    task automatic test_mask_lanes();
        logic [15:0] d;
        wr(ra(0), 16'h0000); wr(ra(6), 16'h0000); wr(ra(8), 16'h0100);
        wr(ca(0, 0), 16'h0000); wr(ca(0, 2), 16'h0103); wr(ca(0, 6), 16'h0001);
        wr(ra(4), 16'h0000); wr(ra(0), 16'h0001);
        for (int k = 0; k < 4; k++) idle();
        rd(ra(2), d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL mask_pend: got %h expected 0001", d); end
        checks++;
        if (irqrun !== 1'b0) begin errors++; $display("FAIL mask_off_irq: got %b expected 0", irqrun); end
        wr(ra(4), 16'h0001);
        checks++;
        if (irqrun !== 1'b1) begin errors++; $display("FAIL mask_on_irq: got %b expected 1", irqrun); end
        step(1'b1, ca(0, 2), 16'hABCD, 2'b10);
        rd(ca(0, 2), d);
        checks++;
        if (d !== 16'hAB03) begin errors++; $display("FAIL lane_hi_only: got %h expected ab03", d); end
    endtask

    task automatic test_random();
        logic [15:0] d, wd;
        logic [7:0]  a;
        int k, ch, sub;
        for (int it = 0; it < 300; it++) begin
            drun = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 24);
            if (k < 5) a = ra(2 * k);
            else if (k < 21) begin
                ch = (k - 5) / 4; sub = ((k - 5) % 4) * 2;
                a = ca(ch, sub);
            end else a = 8'($urandom);
            wd = 16'($urandom);
            // Bias compare writes toward the live count so matches actually occur.
            if (k >= 5 && k < 21 && sub == 2 && $urandom_range(0, 1) == 1)
                wd = 16'((m_count & 'hFFFF) + $urandom_range(0, 6));
            if (k >= 5 && k < 21 && sub == 0) wd = 16'(m_count >> 16);
            if (k >= 5 && k < 21 && sub == 4) wd = 16'($urandom_range(0, 12));
            step($urandom_range(0, 3) != 0, a, wd, 2'($urandom));
            a = (it % 2 == 0) ? ra(2 * $urandom_range(0, 4)) : ca($urandom_range(0, 4), 2 * $urandom_range(0, 3));
            rd(a, d);
            checks++;
            if (d !== mread(a)) begin
                errors++; $display("FAIL random_read %h: got %h expected %h", a, d, mread(a));
            end
            checks++;
            if (irqrun !== mirq()) begin
                errors++; $display("FAIL random_irq: got %b expected %b", irqrun, mirq());
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_races();
        test_wrap();
        test_mask_lanes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
